// File: rtl/myproject_sdiv_24s_8ns_16_seq.sv
// Sequential radix-2 restoring divider: signed dividend / unsigned divisor -> saturated signed quotient + remainder.
// Optional build macro MYPROJECT_SDIV_ROUND_EN selects round-to-nearest (ties away from zero) instead of truncation.
module myproject_sdiv_24s_8ns_16_seq #(
  parameter int DIVIDEND_W = 24,
  parameter int DIVISOR_W  = 8,
  parameter int QUOTIENT_W = 16
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIVIDEND_W-1:0] dividend,
  input  logic        [DIVISOR_W-1:0]  divisor,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [QUOTIENT_W-1:0] quotient,
  output logic signed [DIVISOR_W:0]    remainder,
  output logic                         div_by_zero,
  output logic                         overflow
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [DIVIDEND_W:0]   QMAX_MAG = (DIVIDEND_W+1)'(2**(QUOTIENT_W-1) - 1);
  localparam logic [DIVIDEND_W:0]   QMIN_MAG = (DIVIDEND_W+1)'(2**(QUOTIENT_W-1));
  localparam logic [QUOTIENT_W-1:0] Q_POS    = {1'b0, {(QUOTIENT_W-1){1'b1}}};
  localparam logic [QUOTIENT_W-1:0] Q_NEG    = {1'b1, {(QUOTIENT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t                  state_q;
  logic [DIVISOR_W-1:0]    divisor_q;
  logic                    neg_q;
  logic [DIVIDEND_W-1:0]   mag_q;
  logic [DIVISOR_W:0]      rem_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic [QUOTIENT_W-1:0]   quotient_q;
  logic [DIVISOR_W:0]      remainder_q;
  logic                    dbz_q;
  logic                    ovf_q;

  logic [DIVIDEND_W-1:0]   dvd_u;
  logic [DIVIDEND_W-1:0]   abs_d;
  logic [DIVISOR_W:0]      rem_shift;
  logic                    qbit;
  logic [DIVISOR_W:0]      rem_d;
  logic [DIVIDEND_W:0]     qmag;
  logic [DIVISOR_W:0]      rmag;
  logic [QUOTIENT_W-1:0]   quotient_d;
  logic [DIVISOR_W:0]      remainder_d;
  logic                    ovf_d;
  logic                    dbz_d;

  // mag_q doubles as the quotient shift register: dividend bits leave at the top,
  // quotient bits enter at the bottom, so after DIVIDEND_W steps it holds |q|.
  always_comb begin
    dvd_u     = dividend;
    abs_d     = dvd_u[DIVIDEND_W-1] ? (~dvd_u + DIVIDEND_W'(1)) : dvd_u;
    rem_shift = {rem_q[DIVISOR_W-1:0], mag_q[DIVIDEND_W-1]};
    qbit      = (rem_shift >= {1'b0, divisor_q});
    rem_d     = qbit ? (rem_shift - {1'b0, divisor_q}) : rem_shift;
  end

  always_comb begin
    qmag = {1'b0, mag_q};
    rmag = rem_q;
`ifdef MYPROJECT_SDIV_ROUND_EN
    // rmag goes negative relative to the dividend sign when rounding away from zero
    if ({rem_q, 1'b0} >= {2'b00, divisor_q}) begin
      qmag = qmag + (DIVIDEND_W+1)'(1);
      rmag = rem_q - {1'b0, divisor_q};
    end
`endif
    quotient_d  = neg_q ? (~qmag[QUOTIENT_W-1:0] + QUOTIENT_W'(1)) : qmag[QUOTIENT_W-1:0];
    remainder_d = neg_q ? (~rmag + (DIVISOR_W+1)'(1)) : rmag;
    ovf_d       = 1'b0;
    dbz_d       = 1'b0;
    if (divisor_q == '0) begin
      dbz_d       = 1'b1;
      remainder_d = '0;
      quotient_d  = neg_q ? Q_NEG : ((mag_q != '0) ? Q_POS : '0);
    end else if (!neg_q && (qmag > QMAX_MAG)) begin
      ovf_d       = 1'b1;
      remainder_d = '0;
      quotient_d  = Q_POS;
    end else if (neg_q && (qmag > QMIN_MAG)) begin
      ovf_d       = 1'b1;
      remainder_d = '0;
      quotient_d  = Q_NEG;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= S_IDLE;
      divisor_q   <= '0;
      neg_q       <= 1'b0;
      mag_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            divisor_q  <= divisor;
            neg_q      <= dividend[DIVIDEND_W-1];
            mag_q      <= abs_d;
            rem_q      <= '0;
            cnt_q      <= CNT_W'(DIVIDEND_W);
            in_ready_q <= 1'b0;
            state_q    <= (divisor == '0) ? S_FIX : S_RUN;
          end
        end
        S_RUN: begin
          rem_q <= rem_d;
          mag_q <= {mag_q[DIVIDEND_W-2:0], qbit};
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          quotient_q  <= quotient_d;
          remainder_q <= remainder_d;
          dbz_q       <= dbz_d;
          ovf_q       <= ovf_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        default: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
